// File: rtl/mmio_cmd_pkg.sv
// Register map offsets, STATUS bit positions and CTRL bit positions shared
// by the MMIO command queue and its bench.
package mmio_cmd_pkg;

  // Register offsets from the window base
  localparam int unsigned OFF_CMD    = 32'h00;
  localparam int unsigned OFF_PARAM0 = 32'h04;
  localparam int unsigned OFF_STATUS = 32'h40;
  localparam int unsigned OFF_RET    = 32'h44;
  localparam int unsigned OFF_CTRL   = 32'h48;

  // STATUS bit positions
  localparam int unsigned ST_BUSY        = 0;
  localparam int unsigned ST_CMD_FULL    = 1;
  localparam int unsigned ST_RET_EMPTY   = 2;
  localparam int unsigned ST_CMD_OVF     = 3;
  localparam int unsigned ST_RET_OVF     = 4;
  localparam int unsigned ST_RET_UDF     = 5;
  localparam int unsigned ST_CMD_CNT_LSB = 8;
  localparam int unsigned ST_RET_CNT_LSB = 16;
  localparam int unsigned ST_CNT_W       = 8;

  // CTRL bit positions
  localparam int unsigned CTRL_CLEAR_BIT = 0;
  localparam int unsigned CTRL_FLUSH_BIT = 1;

  // Offset of PARAM register k
  function automatic int unsigned param_off(input int unsigned k);
    return OFF_PARAM0 + 4 * k;
  endfunction

endpackage

// File: rtl/mmio_cmd_queue_if.sv
// Aquila device-bus slave port of the MMIO command queue.
//   S_DEVICE_strobe_i      single-cycle request
//   S_DEVICE_addr_i        byte address
//   S_DEVICE_rw_i          1=write, 0=read
//   S_DEVICE_byte_enable_i write byte lanes
//   S_DEVICE_data_i        write data
//   S_DEVICE_ready_o       completion pulse, one cycle after strobe
//   S_DEVICE_data_o        registered read data
interface mmio_cmd_queue_if #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BUF_ADDR_LEN = 32
);
  localparam int unsigned BE_W = XLEN / 8;

  logic                    S_DEVICE_strobe_i;
  logic [BUF_ADDR_LEN-1:0] S_DEVICE_addr_i;
  logic                    S_DEVICE_rw_i;
  logic [BE_W-1:0]         S_DEVICE_byte_enable_i;
  logic [XLEN-1:0]         S_DEVICE_data_i;
  logic                    S_DEVICE_ready_o;
  logic [XLEN-1:0]         S_DEVICE_data_o;

  modport master (
    output S_DEVICE_strobe_i, S_DEVICE_addr_i, S_DEVICE_rw_i,
           S_DEVICE_byte_enable_i, S_DEVICE_data_i,
    input  S_DEVICE_ready_o, S_DEVICE_data_o
  );

  modport slave (
    input  S_DEVICE_strobe_i, S_DEVICE_addr_i, S_DEVICE_rw_i,
           S_DEVICE_byte_enable_i, S_DEVICE_data_i,
    output S_DEVICE_ready_o, S_DEVICE_data_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush.
//   clk_i, rst_i  clock, synchronous active-low reset
//   i_push/i_din  write request and data (ignored when full unless popping)
//   i_pop         read request (ignored when empty)
//   i_flush       empties the FIFO, overriding push and pop
//   o_dout_c      head entry, zero while empty
//   o_full_c      FIFO full
//   o_empty_c     FIFO empty
//   o_count       number of stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout_c,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout_c  = o_empty_c ? '0 : r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  assign w_do_pop  = i_pop && !o_empty_c && !i_flush;
  assign w_do_push = i_push && (!o_full_c || w_do_pop) && !i_flush;

  // Pointer and occupancy tracking; pointers wrap modulo DEPTH
  always_ff @(posedge clk_i) begin
    if (!rst_i || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage array
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/mmio_cmd_queue.sv
// MMIO command queue between the Aquila device bus and the TPU.
// CMD writes push {opcode, PARAM snapshot} into a command FIFO drained to the
// TPU by valid/ready; TPU results land in a return FIFO popped by RET reads.
//   clk_i, rst_i        clock, synchronous active-low reset
//   s_device            device-bus slave port (mmio_cmd_queue_if.slave)
//   cmd_valid_o         command FIFO not empty
//   cmd_ready_i         TPU accepts the head command
//   cmd_o               head opcode
//   cmd_params_o        head parameter snapshot, param k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ret_valid_i         result strobe (no backpressure)
//   ret_data_i          result data
//   tpu_busy_i          TPU busy, reflected in STATUS
module mmio_cmd_queue
  import mmio_cmd_pkg::*;
#(
  parameter int unsigned                XLEN         = 32,
  parameter int unsigned                BUF_ADDR_LEN = 32,
  parameter logic [BUF_ADDR_LEN-1:0]    BASE_ADDR    = BUF_ADDR_LEN'(32'hC4000000),
  parameter int unsigned                ACLEN        = 8,
  parameter int unsigned                DATA_WIDTH   = 32,
  parameter int unsigned                NUM_PARAMS   = 4,
  parameter int unsigned                CMD_DEPTH    = 4,
  parameter int unsigned                RET_DEPTH    = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  mmio_cmd_queue_if.slave                  s_device,
  output logic                             cmd_valid_o,
  input  logic                             cmd_ready_i,
  output logic [ACLEN-1:0]                 cmd_o,
  output logic [NUM_PARAMS*DATA_WIDTH-1:0] cmd_params_o,
  input  logic                             ret_valid_i,
  input  logic [DATA_WIDTH-1:0]            ret_data_i,
  input  logic                             tpu_busy_i
);

  localparam int unsigned PARAMS_W  = NUM_PARAMS * DATA_WIDTH;
  localparam int unsigned CMD_W     = ACLEN + PARAMS_W;
  localparam int unsigned CMD_CNT_W = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned RET_CNT_W = $clog2(RET_DEPTH) + 1;

  // Bus decode
  logic [BUF_ADDR_LEN-1:0] w_off;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_sel_cmd;
  logic                    w_sel_status;
  logic                    w_sel_ret;
  logic                    w_sel_ctrl;
  logic [NUM_PARAMS-1:0]   w_sel_param;

  // Registers
  logic [NUM_PARAMS-1:0][DATA_WIDTH-1:0] r_param;
  logic [NUM_PARAMS-1:0][DATA_WIDTH-1:0] w_param_nxt;
  logic                                  r_ready;
  logic [XLEN-1:0]                       r_rdata;
  logic                                  r_cmd_ovf;
  logic                                  r_ret_ovf;
  logic                                  r_ret_udf;

  // FIFO control and status
  logic                  w_clear;
  logic                  w_flush;
  logic                  w_cmd_push;
  logic                  w_cmd_pop;
  logic [CMD_W-1:0]      w_cmd_din;
  logic [CMD_W-1:0]      w_cmd_dout;
  logic                  w_cmd_full;
  logic                  w_cmd_empty;
  logic [CMD_CNT_W-1:0]  w_cmd_count;
  logic                  w_ret_rd;
  logic                  w_ret_pop;
  logic [DATA_WIDTH-1:0] w_ret_dout;
  logic                  w_ret_full;
  logic                  w_ret_empty;
  logic [RET_CNT_W-1:0]  w_ret_count;
  logic                  w_cmd_ovf;
  logic                  w_ret_ovf;
  logic                  w_ret_udf;
  logic [XLEN-1:0]       w_status;
  logic [XLEN-1:0]       w_rdata;

  assign w_off        = s_device.S_DEVICE_addr_i - BASE_ADDR;
  assign w_wr         = s_device.S_DEVICE_strobe_i && s_device.S_DEVICE_rw_i;
  assign w_rd         = s_device.S_DEVICE_strobe_i && !s_device.S_DEVICE_rw_i;
  assign w_sel_cmd    = (w_off == BUF_ADDR_LEN'(OFF_CMD));
  assign w_sel_status = (w_off == BUF_ADDR_LEN'(OFF_STATUS));
  assign w_sel_ret    = (w_off == BUF_ADDR_LEN'(OFF_RET));
  assign w_sel_ctrl   = (w_off == BUF_ADDR_LEN'(OFF_CTRL));

  // PARAM register selects
  always_comb begin
    w_sel_param = '0;
    for (int unsigned k = 0; k < NUM_PARAMS; k++) begin
      w_sel_param[k] = (w_off == BUF_ADDR_LEN'(param_off(k)));
    end
  end

  // Byte-merged PARAM update; lanes beyond DATA_WIDTH fall outside the loop
  always_comb begin
    w_param_nxt = r_param;
    if (w_wr) begin
      for (int unsigned k = 0; k < NUM_PARAMS; k++) begin
        if (w_sel_param[k]) begin
          for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
            if (s_device.S_DEVICE_byte_enable_i[b/8]) begin
              w_param_nxt[k][b] = s_device.S_DEVICE_data_i[b];
            end
          end
        end
      end
    end
  end

  // CTRL decode
  assign w_clear = w_wr && w_sel_ctrl && s_device.S_DEVICE_data_i[CTRL_CLEAR_BIT];
  assign w_flush = w_wr && w_sel_ctrl && s_device.S_DEVICE_data_i[CTRL_FLUSH_BIT];

  // Command FIFO: the snapshot uses the registered PARAMs, i.e. pre-write values
  assign w_cmd_push = w_wr && w_sel_cmd;
  assign w_cmd_pop  = cmd_valid_o && cmd_ready_i;
  assign w_cmd_din  = {s_device.S_DEVICE_data_i[ACLEN-1:0], r_param};

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_push    (w_cmd_push),
    .i_pop     (w_cmd_pop),
    .i_flush   (w_flush),
    .i_din     (w_cmd_din),
    .o_dout_c  (w_cmd_dout),
    .o_full_c  (w_cmd_full),
    .o_empty_c (w_cmd_empty),
    .o_count   (w_cmd_count)
  );

  assign cmd_valid_o  = !w_cmd_empty;
  assign cmd_o        = w_cmd_dout[CMD_W-1 -: ACLEN];
  assign cmd_params_o = w_cmd_dout[PARAMS_W-1:0];

  // Return FIFO: a RET read pops only when something is there
  assign w_ret_rd  = w_rd && w_sel_ret;
  assign w_ret_pop = w_ret_rd && !w_ret_empty;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RET_DEPTH)
  ) u_ret_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_push    (ret_valid_i),
    .i_pop     (w_ret_pop),
    .i_flush   (w_flush),
    .i_din     (ret_data_i),
    .o_dout_c  (w_ret_dout),
    .o_full_c  (w_ret_full),
    .o_empty_c (w_ret_empty),
    .o_count   (w_ret_count)
  );

  // Error events; a same-cycle pop makes room, a flush discards the push
  assign w_cmd_ovf = w_cmd_push && w_cmd_full && !w_cmd_pop && !w_flush;
  assign w_ret_ovf = ret_valid_i && w_ret_full && !w_ret_pop && !w_flush;
  assign w_ret_udf = w_ret_rd && w_ret_empty;

  // STATUS image
  always_comb begin
    w_status                                = '0;
    w_status[ST_BUSY]                       = tpu_busy_i || cmd_valid_o;
    w_status[ST_CMD_FULL]                   = w_cmd_full;
    w_status[ST_RET_EMPTY]                  = w_ret_empty;
    w_status[ST_CMD_OVF]                    = r_cmd_ovf;
    w_status[ST_RET_OVF]                    = r_ret_ovf;
    w_status[ST_RET_UDF]                    = r_ret_udf;
    w_status[ST_CMD_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(w_cmd_count);
    w_status[ST_RET_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(w_ret_count);
  end

  // Read mux; write-only and unmapped offsets read as zero
  always_comb begin
    w_rdata = '0;
    if (w_sel_status) w_rdata = w_status;
    if (w_sel_ret)    w_rdata = XLEN'(w_ret_dout);
    for (int unsigned k = 0; k < NUM_PARAMS; k++) begin
      if (w_sel_param[k]) w_rdata = XLEN'(r_param[k]);
    end
  end

  // Register state, bus response and sticky flags (new errors beat a clear)
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_param   <= '0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_cmd_ovf <= 1'b0;
      r_ret_ovf <= 1'b0;
      r_ret_udf <= 1'b0;
    end else begin
      r_param   <= w_param_nxt;
      r_ready   <= s_device.S_DEVICE_strobe_i;
      if (w_rd) r_rdata <= w_rdata;
      r_cmd_ovf <= (r_cmd_ovf && !w_clear) || w_cmd_ovf;
      r_ret_ovf <= (r_ret_ovf && !w_clear) || w_ret_ovf;
      r_ret_udf <= (r_ret_udf && !w_clear) || w_ret_udf;
    end
  end

  assign s_device.S_DEVICE_ready_o = r_ready;
  assign s_device.S_DEVICE_data_o  = r_rdata;

endmodule

// File: tb/tb_mmio_cmd_queue.sv
// Directed bench for mmio_cmd_queue with hand-computed expectations.
module tb_mmio_cmd_queue;
  import mmio_cmd_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned ACLEN = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned NP    = 4;
  localparam logic [31:0] BASE  = 32'hC4000000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  mmio_cmd_queue_if #(.XLEN(XLEN), .BUF_ADDR_LEN(AW)) bus ();

  logic               cmd_valid_o;
  logic               cmd_ready_i;
  logic [ACLEN-1:0]   cmd_o;
  logic [NP*DW-1:0]   cmd_params_o;
  logic               ret_valid_i;
  logic [DW-1:0]      ret_data_i;
  logic               tpu_busy_i;

  mmio_cmd_queue #(
    .XLEN         (XLEN),
    .BUF_ADDR_LEN (AW),
    .BASE_ADDR    (BASE),
    .ACLEN        (ACLEN),
    .DATA_WIDTH   (DW),
    .NUM_PARAMS   (NP),
    .CMD_DEPTH    (4),
    .RET_DEPTH    (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .s_device     (bus),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_ready_i  (cmd_ready_i),
    .cmd_o        (cmd_o),
    .cmd_params_o (cmd_params_o),
    .ret_valid_i  (ret_valid_i),
    .ret_data_i   (ret_data_i),
    .tpu_busy_i   (tpu_busy_i)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] rd_data;
  logic        rd_rdy;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One bus transaction; leaves time at posedge+1 with the response sampled
  task automatic bus_xfer(input logic rw, input logic [31:0] off,
                          input logic [31:0] wdata, input logic [3:0] be);
    bus.S_DEVICE_strobe_i      = 1'b1;
    bus.S_DEVICE_rw_i          = rw;
    bus.S_DEVICE_addr_i        = BASE + off;
    bus.S_DEVICE_data_i        = wdata;
    bus.S_DEVICE_byte_enable_i = be;
    @(posedge clk_i); #1;
    bus.S_DEVICE_strobe_i      = 1'b0;
    bus.S_DEVICE_rw_i          = 1'b0;
    rd_data = bus.S_DEVICE_data_o;
    rd_rdy  = bus.S_DEVICE_ready_o;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] wdata);
    bus_xfer(1'b1, off, wdata, 4'hF);
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] off, input logic [31:0] exp);
    bus_xfer(1'b0, off, 32'h0, 4'h0);
    expect_eq(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic ret_push(input logic [31:0] d);
    ret_valid_i = 1'b1;
    ret_data_i  = d;
    @(posedge clk_i); #1;
    ret_valid_i = 1'b0;
  endtask

  initial begin
    bus.S_DEVICE_strobe_i      = 1'b0;
    bus.S_DEVICE_rw_i          = 1'b0;
    bus.S_DEVICE_addr_i        = '0;
    bus.S_DEVICE_data_i        = '0;
    bus.S_DEVICE_byte_enable_i = '0;
    cmd_ready_i = 1'b0;
    ret_valid_i = 1'b0;
    ret_data_i  = '0;
    tpu_busy_i  = 1'b0;

    // Reset state
    idle(3);
    expect_eq("rst_ready", 64'(bus.S_DEVICE_ready_o), 64'd0);
    expect_eq("rst_data", 64'(bus.S_DEVICE_data_o), 64'd0);
    expect_eq("rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
    rst_i = 1'b1;
    rd_expect("status_after_reset", OFF_STATUS, 32'h0000_0004);
    expect_eq("ready_pulse", 64'(rd_rdy), 64'd1);
    idle(1);
    expect_eq("ready_drops", 64'(bus.S_DEVICE_ready_o), 64'd0);

    // Byte-merged PARAM write and unmapped access
    wr(OFF_PARAM0, 32'h1122_3344);
    bus_xfer(1'b1, OFF_PARAM0, 32'hAABB_CCDD, 4'b0010);
    rd_expect("param0_merge", OFF_PARAM0, 32'h1122_CC44);
    wr(32'h7C, 32'hFFFF_FFFF);
    expect_eq("unmapped_wr_ready", 64'(rd_rdy), 64'd1);
    rd_expect("unmapped_rd", 32'h7C, 32'h0);
    expect_eq("unmapped_rd_ready", 64'(rd_rdy), 64'd1);

    // Command FIFO overflow with TPU stalled
    for (int i = 1; i <= 5; i++) wr(OFF_CMD, 32'(i));
    expect_eq("cmd_valid_full", 64'(cmd_valid_o), 64'd1);
    expect_eq("cmd_head_first", 64'(cmd_o), 64'h01);
    expect_eq("cmd_head_p0", 64'(cmd_params_o[31:0]), 64'h1122_CC44);
    rd_expect("status_cmd_full", OFF_STATUS, 32'h0000_040F);
    cmd_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      expect_eq($sformatf("drain_op%0d", i), 64'(cmd_o), 64'(i));
      expect_eq($sformatf("drain_valid%0d", i), 64'(cmd_valid_o), 64'd1);
      @(posedge clk_i); #1;
    end
    cmd_ready_i = 1'b0;
    expect_eq("cmd_empty_after_drain", 64'(cmd_valid_o), 64'd0);
    wr(OFF_CTRL, 32'h1);
    rd_expect("status_cleared", OFF_STATUS, 32'h0000_0004);

    // PARAM snapshot at push time
    wr(OFF_PARAM0 + 4, 32'd7);
    wr(OFF_CMD, 32'h10);
    wr(OFF_PARAM0 + 4, 32'd9);
    wr(OFF_CMD, 32'h11);
    expect_eq("snap_op0", 64'(cmd_o), 64'h10);
    expect_eq("snap_p1_old", 64'(cmd_params_o[63:32]), 64'd7);
    cmd_ready_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_ready_i = 1'b0;
    expect_eq("snap_op1", 64'(cmd_o), 64'h11);
    expect_eq("snap_p1_new", 64'(cmd_params_o[63:32]), 64'd9);
    cmd_ready_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_ready_i = 1'b0;
    expect_eq("snap_empty", 64'(cmd_valid_o), 64'd0);

    // Return path, underflow and clear
    ret_push(32'hA);
    ret_push(32'hB);
    rd_expect("ret_a", OFF_RET, 32'hA);
    rd_expect("ret_b", OFF_RET, 32'hB);
    rd_expect("ret_udf_data", OFF_RET, 32'h0);
    rd_expect("status_udf", OFF_STATUS, 32'h0000_0024);
    wr(OFF_CTRL, 32'h1);
    rd_expect("status_udf_clr", OFF_STATUS, 32'h0000_0004);

    // Full return FIFO with simultaneous push and pop, then overflow
    for (int i = 1; i <= 4; i++) ret_push(32'(i));
    rd_expect("status_ret_full", OFF_STATUS, 32'h0004_0000);
    ret_valid_i = 1'b1;
    ret_data_i  = 32'd5;
    rd_expect("ret_pushpop", OFF_RET, 32'd1);
    ret_valid_i = 1'b0;
    rd_expect("status_pushpop", OFF_STATUS, 32'h0004_0000);
    ret_push(32'd6);
    rd_expect("status_ret_ovf", OFF_STATUS, 32'h0004_0010);
    for (int i = 2; i <= 5; i++) rd_expect($sformatf("ret_drain%0d", i), OFF_RET, 32'(i));
    rd_expect("status_drained", OFF_STATUS, 32'h0000_0014);

    // Flush plus clear
    wr(OFF_CMD, 32'h20);
    wr(OFF_CMD, 32'h21);
    ret_push(32'd7);
    rd_expect("status_pre_flush", OFF_STATUS, 32'h0001_0211);
    wr(OFF_CTRL, 32'h3);
    expect_eq("flush_cmd_valid", 64'(cmd_valid_o), 64'd0);
    rd_expect("status_flushed", OFF_STATUS, 32'h0000_0004);

    // Busy from TPU
    tpu_busy_i = 1'b1;
    rd_expect("status_tpu_busy", OFF_STATUS, 32'h0000_0005);
    tpu_busy_i = 1'b0;

    // Reset in the middle of traffic
    wr(OFF_CMD, 32'h30);
    ret_push(32'd8);
    rd_expect("pre_rst_param0", OFF_PARAM0, 32'h1122_CC44);
    expect_eq("pre_rst_valid", 64'(cmd_valid_o), 64'd1);
    rst_i                 = 1'b0;
    bus.S_DEVICE_strobe_i = 1'b1;
    bus.S_DEVICE_rw_i     = 1'b1;
    bus.S_DEVICE_addr_i   = BASE + OFF_CMD;
    bus.S_DEVICE_data_i   = 32'h31;
    ret_valid_i           = 1'b1;
    ret_data_i            = 32'd9;
    @(posedge clk_i); #1;
    bus.S_DEVICE_strobe_i = 1'b0;
    bus.S_DEVICE_rw_i     = 1'b0;
    ret_valid_i           = 1'b0;
    expect_eq("mid_rst_ready", 64'(bus.S_DEVICE_ready_o), 64'd0);
    expect_eq("mid_rst_data", 64'(bus.S_DEVICE_data_o), 64'd0);
    expect_eq("mid_rst_valid", 64'(cmd_valid_o), 64'd0);
    expect_eq("mid_rst_cmd", 64'(cmd_o), 64'd0);
    expect_eq("mid_rst_params", 64'(cmd_params_o[63:0]), 64'd0);
    rst_i = 1'b1;
    rd_expect("post_rst_status", OFF_STATUS, 32'h0000_0004);
    rd_expect("post_rst_param0", OFF_PARAM0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
